serial_operand_feeder: RTL and testbench

SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

---
 rtl/serial_operand_feeder.sv | 120 ++++++++++++
 tb/tb_serial_operand_feeder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_feeder.sv
// Feeds an operand pair MSB-first, one bit per cycle, into a downstream serial comparator.
// A one-deep pending buffer lets the next pair be accepted while the current one is shifting.
module serial_operand_feeder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  output logic             cmp_clr,
  output logic             last_bit,
  output logic             done,
  output logic             busy
);

  localparam int unsigned    CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, pa, pb;
  logic [WIDTH-1:0] sa_nxt, sb_nxt, pa_nxt, pb_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             pend_valid, pend_nxt;
  logic             transfer;
  logic             live;

  assign ready    = !pend_valid && !rst;
  assign transfer = load && ready;
  assign live     = !rst;

  always_comb begin
    state_nxt = state;
    sa_nxt    = sa;
    sb_nxt    = sb;
    pa_nxt    = pa;
    pb_nxt    = pb;
    cnt_nxt   = cnt;
    pend_nxt  = pend_valid;
    case (state)
      IDLE: begin
        // A pair left pending by a transfer during DONE starts from here.
        if (pend_valid) begin
          sa_nxt    = pa;
          sb_nxt    = pb;
          pend_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = CLEAR;
        end else if (transfer) begin
          sa_nxt    = a_in;
          sb_nxt    = b_in;
          cnt_nxt   = '0;
          state_nxt = CLEAR;
        end
      end
      CLEAR: state_nxt = SHIFT;
      SHIFT: begin
        sa_nxt  = sa << 1;
        sb_nxt  = sb << 1;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        if (pend_valid) begin
          sa_nxt    = pa;
          sb_nxt    = pb;
          pend_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = CLEAR;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Outside IDLE a transfer always lands in the pending buffer; ready keeps it
    // from colliding with the DONE-state drain of that buffer.
    if (transfer && state != IDLE) begin
      pa_nxt   = a_in;
      pb_nxt   = b_in;
      pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      pa         <= '0;
      pb         <= '0;
      cnt        <= '0;
      pend_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      sa         <= sa_nxt;
      sb         <= sb_nxt;
      pa         <= pa_nxt;
      pb         <= pb_nxt;
      cnt        <= cnt_nxt;
      pend_valid <= pend_nxt;
    end
  end

  // Outputs are forced low while rst is held so an aborted operation emits nothing.
  assign cmp_clr   = live && (state == CLEAR);
  assign bit_valid = live && (state == SHIFT);
  assign a_bit     = bit_valid && sa[WIDTH-1];
  assign b_bit     = bit_valid && sb[WIDTH-1];
  assign last_bit  = bit_valid && (cnt == CNT_LAST);
  assign done      = live && (state == DONE);
  assign busy      = live && (state != IDLE);

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder: WIDTH=8 main instance plus a WIDTH=1 instance,
// each feeding a behavioural MSB-first serial comparator.
module tb_serial_operand_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, load1;
  logic [7:0] a_in, b_in;
  logic [0:0] a1, b1;
  logic       ready, a_bit, b_bit, bit_valid, cmp_clr, last_bit, done, busy;
  logic       ready1, a_bit1, b_bit1, bit_valid1, cmp_clr1, last_bit1, done1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_operand_feeder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load(load), .a_in(a_in), .b_in(b_in),
    .ready(ready), .a_bit(a_bit), .b_bit(b_bit), .bit_valid(bit_valid),
    .cmp_clr(cmp_clr), .last_bit(last_bit), .done(done), .busy(busy)
  );

  serial_operand_feeder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .a_in(a1), .b_in(b1),
    .ready(ready1), .a_bit(a_bit1), .b_bit(b_bit1), .bit_valid(bit_valid1),
    .cmp_clr(cmp_clr1), .last_bit(last_bit1), .done(done1), .busy(busy1)
  );

  // Downstream comparator models: 0 = A<B, 1 = equal, 2 = A>B
  logic gt, lt, gt1, lt1;
  always @(posedge clk) begin
    if (cmp_clr) begin
      gt <= 1'b0; lt <= 1'b0;
    end else if (bit_valid && !gt && !lt) begin
      if (a_bit && !b_bit) gt <= 1'b1;
      else if (!a_bit && b_bit) lt <= 1'b1;
    end
    if (cmp_clr1) begin
      gt1 <= 1'b0; lt1 <= 1'b0;
    end else if (bit_valid1 && !gt1 && !lt1) begin
      if (a_bit1 && !b_bit1) gt1 <= 1'b1;
      else if (!a_bit1 && b_bit1) lt1 <= 1'b1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cmp_res(input logic g, input logic l);
    return g ? 2 : (l ? 0 : 1);
  endfunction

  // Entered while the DUT shows its CLEAR cycle; leaves at the done cycle.
  // side_at >= 0 loads (sa_v,sb_v) into pending during that bit, then holds load with
  // different values while pending is full to prove they are ignored.
  task automatic stream(input logic [7:0] a, input logic [7:0] b, input int exp_cmp,
                        input int side_at, input logic [7:0] sa_v, input logic [7:0] sb_v);
    check("clr", cmp_clr, 1);
    check("clr_bv", bit_valid, 0);
    check("clr_abit", a_bit, 0);
    check("clr_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("bv%0d", i), bit_valid, 1);
      check($sformatf("abit%0d", i), a_bit, a[7-i]);
      check($sformatf("bbit%0d", i), b_bit, b[7-i]);
      check($sformatf("last%0d", i), last_bit, (i == 7) ? 1 : 0);
      check($sformatf("clr_in_shift%0d", i), cmp_clr, 0);
      if (side_at >= 0) begin
        if (i == side_at) begin
          check("ready_before_pend", ready, 1);
          load = 1'b1; a_in = sa_v; b_in = sb_v;
        end else if (i == side_at + 1) begin
          check("ready_pend_full", ready, 0);
          a_in = 8'h33; b_in = 8'h44;
        end else if (i == side_at + 3) begin
          load = 1'b0;
        end
      end
    end
    tick();
    check("done", done, 1);
    check("done_bv", bit_valid, 0);
    check("done_abit", a_bit, 0);
    check("done_last", last_bit, 0);
    check("cmp_result", cmp_res(gt, lt), exp_cmp);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load1 = 1'b0;
    a_in = '0; b_in = '0; a1 = '0; b1 = '0;
    tick();
    load = 1'b1;
    tick();
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_bv", bit_valid, 0);
    check("rst_clr", cmp_clr, 0);
    load = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_ready", ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_abit", a_bit, 0);

    // A5 vs 5A, second pair 0F/10 queued during SHIFT, a third pair offered while full
    load = 1'b1; a_in = 8'hA5; b_in = 8'h5A;
    tick();
    load = 1'b0;
    stream(8'hA5, 8'h5A, 2, 1, 8'h0F, 8'h10);
    check("done1_ready", ready, 0);
    tick();
    check("b2b_ready", ready, 1);
    stream(8'h0F, 8'h10, 0, -1, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("idle_done%0d", i), done, 0);
      check($sformatf("idle_busy%0d", i), busy, 0);
      check($sformatf("idle_clr%0d", i), cmp_clr, 0);
    end

    // Reset in the third SHIFT cycle with pending full
    load = 1'b1; a_in = 8'h12; b_in = 8'h34;
    tick();
    a_in = 8'h56; b_in = 8'h78;
    tick();
    load = 1'b0;
    check("abort_ready_pend", ready, 0);
    tick();
    tick();
    check("abort_in_shift", bit_valid, 1);
    rst = 1'b1;
    #1;
    check("abort_rst_bv", bit_valid, 0);
    check("abort_rst_ready", ready, 0);
    tick();
    check("abort_busy", busy, 0);
    check("abort_bv", bit_valid, 0);
    check("abort_done", done, 0);
    check("abort_ready_in_rst", ready, 0);
    rst = 1'b0;
    #1;
    check("abort_ready_rel", ready, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("abort_no_done%0d", i), done, 0);
      check($sformatf("abort_no_busy%0d", i), busy, 0);
    end

    // FF vs FF, then a transfer on the DONE cycle that must restart via IDLE
    load = 1'b1; a_in = 8'hFF; b_in = 8'hFF;
    tick();
    load = 1'b0;
    stream(8'hFF, 8'hFF, 1, -1, 8'h00, 8'h00);
    check("done_ready_empty", ready, 1);
    load = 1'b1; a_in = 8'h3C; b_in = 8'hC3;
    tick();
    load = 1'b0;
    check("via_idle_busy", busy, 0);
    check("via_idle_clr", cmp_clr, 0);
    check("via_idle_ready", ready, 0);
    tick();
    stream(8'h3C, 8'hC3, 0, -1, 8'h00, 8'h00);
    tick();
    check("final_busy", busy, 0);

    // WIDTH=1 instance
    load1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    tick();
    load1 = 1'b0;
    check("w1_clr", cmp_clr1, 1);
    check("w1_clr_bv", bit_valid1, 0);
    tick();
    check("w1_bv", bit_valid1, 1);
    check("w1_last", last_bit1, 1);
    check("w1_abit", a_bit1, 1);
    check("w1_bbit", b_bit1, 0);
    tick();
    check("w1_done", done1, 1);
    check("w1_bv_off", bit_valid1, 0);
    check("w1_cmp", cmp_res(gt1, lt1), 2);
    tick();
    check("w1_idle", busy1, 0);
    check("w1_no_done", done1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
